// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single data-memory port, one transaction outstanding.
// Optional watchdog: define DMEM_TIMEOUT_EN to enable the REQ/RESP timeout counter.
module dmem_arbiter #(
    parameter bit          PRIO_FIXED     = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_m0_req,
    input  logic        i_m0_we,
    input  logic [3:0]  i_m0_be,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    output logic        o_m0_gnt,
    output logic        o_m0_rvalid,
    output logic [31:0] o_m0_rdata,
    output logic        o_m0_err,
    input  logic        i_m1_req,
    input  logic        i_m1_we,
    input  logic [3:0]  i_m1_be,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    output logic        o_m1_gnt,
    output logic        o_m1_rvalid,
    output logic [31:0] o_m1_rdata,
    output logic        o_m1_err,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i
);
    localparam logic [31:0] IDLE_RDATA = 32'hbabecafe;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e      state_q;
    logic        owner_q, rr_ptr_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q, wdata_q;

    logic        win_d;
    logic        to_hit, to_fire;
    logic        dm_gnt, dm_rsp, gnt_ev, rsp_ev;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always_comb begin
        if (PRIO_FIXED) win_d = !i_m0_req;
        else            win_d = (i_m0_req && i_m1_req) ? rr_ptr_q : i_m1_req;
    end

`ifdef DMEM_TIMEOUT_EN
    logic [7:0] cnt_q;
    // Held at zero in IDLE so every REQ entry starts from a cleared count.
    always_ff @(posedge i_clk) begin
        if (i_rst || state_q == IDLE) cnt_q <= 8'd0;
        else if (cnt_q != 8'hff)      cnt_q <= cnt_q + 8'd1;
    end
    assign to_hit = (state_q != IDLE) && (cnt_q >= 8'(TIMEOUT_CYCLES - 1));
`else
    assign to_hit = 1'b0;
`endif

    assign dm_gnt    = (state_q == REQ)  && data_gnt_i;
    assign dm_rsp    = (state_q == RESP) && data_rvalid_i;
    assign to_fire   = to_hit && !dm_gnt && !dm_rsp;
    assign gnt_ev    = dm_gnt || (to_fire && state_q == REQ);
    assign rsp_ev    = dm_rsp || to_fire;
    assign rsp_rdata = to_fire ? IDLE_RDATA : data_rdata_i;
    assign rsp_err   = to_fire || data_err_i;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= 4'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
        end else begin
            case (state_q)
                IDLE: if (i_m0_req || i_m1_req) begin
                    owner_q <= win_d;
                    we_q    <= win_d ? i_m1_we    : i_m0_we;
                    be_q    <= win_d ? i_m1_be    : i_m0_be;
                    addr_q  <= win_d ? i_m1_addr  : i_m0_addr;
                    wdata_q <= win_d ? i_m1_wdata : i_m0_wdata;
                    state_q <= REQ;
                end
                REQ: if (gnt_ev) begin
                    rr_ptr_q <= ~owner_q;
                    state_q  <= to_fire ? IDLE : RESP;
                end
                RESP: if (rsp_ev) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_req_o   = (state_q == REQ);
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_addr_o  = addr_q;
    assign data_wdata_o = wdata_q;

    assign o_m0_gnt    = gnt_ev && !owner_q;
    assign o_m1_gnt    = gnt_ev &&  owner_q;
    assign o_m0_rvalid = rsp_ev && !owner_q;
    assign o_m1_rvalid = rsp_ev &&  owner_q;
    assign o_m0_rdata  = o_m0_rvalid ? rsp_rdata : IDLE_RDATA;
    assign o_m1_rdata  = o_m1_rvalid ? rsp_rdata : IDLE_RDATA;
    assign o_m0_err    = o_m0_rvalid && rsp_err;
    assign o_m1_err    = o_m1_rvalid && rsp_err;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (pending set, round-robin preference, expected response).
module tb_dmem_arbiter;
    localparam logic [31:0] IDLE_RD = 32'hbabecafe;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_m0_req, i_m0_we, i_m1_req, i_m1_we;
    logic [3:0]  i_m0_be, i_m1_be;
    logic [31:0] i_m0_addr, i_m0_wdata, i_m1_addr, i_m1_wdata;
    logic        o_m0_gnt, o_m0_rvalid, o_m0_err, o_m1_gnt, o_m1_rvalid, o_m1_err;
    logic [31:0] o_m0_rdata, o_m1_rdata;
    logic        data_req_o, data_we_o, data_gnt_i, data_rvalid_i, data_err_i;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;

    // second instance, fixed priority
    logic        fx_m0_req, fx_m1_req;
    logic        fx_m0_gnt, fx_m0_rvalid, fx_m0_err, fx_m1_gnt, fx_m1_rvalid, fx_m1_err;
    logic [31:0] fx_m0_rdata, fx_m1_rdata;
    logic        fx_req_o, fx_we_o, fx_gnt_i, fx_rvalid_i;
    logic [3:0]  fx_be_o;
    logic [31:0] fx_addr_o, fx_wdata_o;

    always #5 i_clk = ~i_clk;

    dmem_arbiter #(.PRIO_FIXED(1'b0), .TIMEOUT_CYCLES(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_m0_req(i_m0_req), .i_m0_we(i_m0_we), .i_m0_be(i_m0_be), .i_m0_addr(i_m0_addr),
        .i_m0_wdata(i_m0_wdata), .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid),
        .o_m0_rdata(o_m0_rdata), .o_m0_err(o_m0_err),
        .i_m1_req(i_m1_req), .i_m1_we(i_m1_we), .i_m1_be(i_m1_be), .i_m1_addr(i_m1_addr),
        .i_m1_wdata(i_m1_wdata), .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid),
        .o_m1_rdata(o_m1_rdata), .o_m1_err(o_m1_err),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i)
    );

    dmem_arbiter #(.PRIO_FIXED(1'b1), .TIMEOUT_CYCLES(255)) dut_fx (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_m0_req(fx_m0_req), .i_m0_we(1'b0), .i_m0_be(4'hf), .i_m0_addr(32'h10),
        .i_m0_wdata(32'h0), .o_m0_gnt(fx_m0_gnt), .o_m0_rvalid(fx_m0_rvalid),
        .o_m0_rdata(fx_m0_rdata), .o_m0_err(fx_m0_err),
        .i_m1_req(fx_m1_req), .i_m1_we(1'b1), .i_m1_be(4'h1), .i_m1_addr(32'h20),
        .i_m1_wdata(32'h55), .o_m1_gnt(fx_m1_gnt), .o_m1_rvalid(fx_m1_rvalid),
        .o_m1_rdata(fx_m1_rdata), .o_m1_err(fx_m1_err),
        .data_req_o(fx_req_o), .data_we_o(fx_we_o), .data_be_o(fx_be_o),
        .data_addr_o(fx_addr_o), .data_wdata_o(fx_wdata_o), .data_gnt_i(fx_gnt_i),
        .data_rvalid_i(fx_rvalid_i), .data_rdata_i(32'h1234), .data_err_i(1'b0)
    );

    typedef struct packed {
        logic        req_seen, stable, req_dropped, spur;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr, wdata;
        logic        g0, g1, rv0, rv1, e0, e1;
        logic [31:0] rd0, rd1;
    } obs_t;

    int tests = 0, fails = 0;
    bit rr_m;   // model: requester preferred on a tie

    task automatic drive(input bit m, input bit req, input logic [68:0] a);
        if (!m) begin i_m0_req = req; {i_m0_we, i_m0_be, i_m0_addr, i_m0_wdata} = a; end
        else    begin i_m1_req = req; {i_m1_we, i_m1_be, i_m1_addr, i_m1_wdata} = a; end
    endtask

    // Plays the dmem slave for one transaction from the IDLE negedge; records observations only.
    task automatic serve(input int gdly, input int rdly, input logic [31:0] rd, input bit er,
                         output obs_t o);
        o = '0;
        @(posedge i_clk); @(negedge i_clk); #1;
        o.req_seen = data_req_o; o.we = data_we_o; o.be = data_be_o;
        o.addr = data_addr_o; o.wdata = data_wdata_o; o.stable = 1'b1;
        for (int k = 0; k < gdly; k++) begin
            data_rvalid_i = 1'($urandom_range(0, 1)); #1;
            if (o_m0_rvalid | o_m1_rvalid | o_m0_gnt | o_m1_gnt) o.spur = 1'b1;
            @(posedge i_clk); @(negedge i_clk); data_rvalid_i = 1'b0; #1;
            if ({data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o} !==
                {1'b1, o.we, o.be, o.addr, o.wdata}) o.stable = 1'b0;
        end
        data_gnt_i = 1'b1; #1;
        o.g0 = o_m0_gnt; o.g1 = o_m1_gnt;
        @(posedge i_clk); @(negedge i_clk);
        data_gnt_i = 1'b0;
        if (o.g0) i_m0_req = 1'b0;
        if (o.g1) i_m1_req = 1'b0;
        #1 o.req_dropped = !data_req_o;
        for (int k = 0; k < rdly; k++) begin
            data_gnt_i = 1'($urandom_range(0, 1)); #1;
            if (o_m0_rvalid | o_m1_rvalid | o_m0_gnt | o_m1_gnt) o.spur = 1'b1;
            @(posedge i_clk); @(negedge i_clk); data_gnt_i = 1'b0;
        end
        data_rvalid_i = 1'b1; data_rdata_i = rd; data_err_i = er; #1;
        o.rv0 = o_m0_rvalid; o.rv1 = o_m1_rvalid; o.e0 = o_m0_err; o.e1 = o_m1_err;
        o.rd0 = o_m0_rdata; o.rd1 = o_m1_rdata;
        @(posedge i_clk); @(negedge i_clk);
        data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = $urandom;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        drive(0, 0, '0); drive(1, 0, '0);
        data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0; data_rdata_i = 0;
        fx_m0_req = 0; fx_m1_req = 0; fx_gnt_i = 0; fx_rvalid_i = 0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk); i_rst = 1'b0; rr_m = 1'b0; #1;
        tests++;
        if ({data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o} !== 70'd0) begin
            fails++; $display("FAIL reset_dmem: got %h exp 0",
                {data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o});
        end
        tests++;
        if ({o_m0_gnt, o_m0_rvalid, o_m0_err, o_m1_gnt, o_m1_rvalid, o_m1_err, o_m0_rdata, o_m1_rdata}
            !== {6'b0, IDLE_RD, IDLE_RD}) begin
            fails++; $display("FAIL reset_req_side: got %b %h %h exp 000000 babecafe babecafe",
                {o_m0_gnt, o_m0_rvalid, o_m0_err, o_m1_gnt, o_m1_rvalid, o_m1_err}, o_m0_rdata, o_m1_rdata);
        end
        data_gnt_i = 1; data_rvalid_i = 1; data_rdata_i = 32'h1111; #1;
        tests++;
        if ({o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid, o_m0_rdata} !== {4'b0, IDLE_RD}) begin
            fails++; $display("FAIL idle_stray: got %b %h exp 0000 babecafe",
                {o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid}, o_m0_rdata);
        end
        @(posedge i_clk); @(negedge i_clk); data_gnt_i = 0; data_rvalid_i = 0; #1;
        tests++;
        if (data_req_o !== 1'b0) begin
            fails++; $display("FAIL idle_stay: data_req_o got %b exp 0", data_req_o);
        end
    endtask

    task automatic test_rr_order();
        obs_t o;
        logic [1:0] exp_g [5] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        drive(0, 1, {1'b0, 4'hf, 32'h200, 32'h0});
        drive(1, 1, {1'b1, 4'h3, 32'h300, 32'h77});
        for (int i = 0; i < 5; i++) begin
            if (i == 2) drive(0, 1, {1'b0, 4'hf, 32'h204, 32'h0});
            if (i == 3) begin
                drive(0, 1, {1'b0, 4'hf, 32'h208, 32'h0});
                drive(1, 1, {1'b1, 4'hc, 32'h304, 32'h99});
            end
            serve(0, 0, 32'h0, 1'b0, o);
            tests++;
            if ({o.g0, o.g1} !== exp_g[i]) begin
                fails++; $display("FAIL rr_order%0d: gnt got %b exp %b", i, {o.g0, o.g1}, exp_g[i]);
            end
        end
        rr_m = 1'b1;
    endtask

    task automatic test_single_load();
        obs_t o;
        drive(0, 1, {1'b0, 4'hf, 32'h100, 32'h0});
        serve(0, 0, 32'hdeadbeef, 1'b0, o);
        tests++;
        if ({o.req_seen, o.we, o.addr, o.g0, o.g1} !== {2'b10, 32'h100, 2'b10}) begin
            fails++; $display("FAIL load_req: got %b %b %h %b exp 1 0 00000100 10",
                o.req_seen, o.we, o.addr, {o.g0, o.g1});
        end
        tests++;
        if ({o.rv0, o.rv1, o.e0, o.e1, o.rd0, o.rd1} !== {4'b1000, 32'hdeadbeef, IDLE_RD}) begin
            fails++; $display("FAIL load_resp: got %b %h %h exp 1000 deadbeef babecafe",
                {o.rv0, o.rv1, o.e0, o.e1}, o.rd0, o.rd1);
        end
        rr_m = 1'b1;
    endtask

    task automatic test_store_err();
        obs_t o;
        drive(1, 1, {1'b1, 4'b0011, 32'h4000, 32'hcafe0011});
        serve(5, 1, 32'h0, 1'b1, o);
        tests++;
        if ({o.stable, o.spur, o.we, o.be, o.addr, o.wdata} !==
            {3'b101, 4'b0011, 32'h4000, 32'hcafe0011}) begin
            fails++; $display("FAIL store_hold: got %b %b %b %b %h %h exp 1 0 1 0011 00004000 cafe0011",
                o.stable, o.spur, o.we, o.be, o.addr, o.wdata);
        end
        tests++;
        if ({o.g0, o.g1, o.rv0, o.rv1, o.e0, o.e1} !== 6'b010101) begin
            fails++; $display("FAIL store_err: got %b exp 010101", {o.g0, o.g1, o.rv0, o.rv1, o.e0, o.e1});
        end
        rr_m = 1'b0;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        drive(0, 1, {1'b0, 4'hf, 32'h500, 32'h0});
        @(posedge i_clk); @(negedge i_clk); data_gnt_i = 1;
        @(posedge i_clk); @(negedge i_clk); data_gnt_i = 0; i_m0_req = 0;
        i_rst = 1;
        @(posedge i_clk); @(negedge i_clk); i_rst = 0;
        data_rvalid_i = 1; data_rdata_i = 32'h600d; #1;
        tests++;
        if ({data_req_o, o_m0_rvalid, o_m1_rvalid, o_m0_rdata} !== {3'b000, IDLE_RD}) begin
            fails++; $display("FAIL rst_mid_drop: got %b %h exp 000 babecafe",
                {data_req_o, o_m0_rvalid, o_m1_rvalid}, o_m0_rdata);
        end
        @(posedge i_clk); @(negedge i_clk); data_rvalid_i = 0;
        // m0 was granted before reset; a cleared pointer must still prefer m0
        drive(0, 1, {1'b0, 4'h1, 32'h504, 32'h0});
        drive(1, 1, {1'b0, 4'h2, 32'h508, 32'h0});
        serve(0, 0, 32'h0, 1'b0, o);
        tests++;
        if ({o.g0, o.g1} !== 2'b10) begin
            fails++; $display("FAIL rst_mid_rr: gnt got %b exp 10", {o.g0, o.g1});
        end
        serve(0, 0, 32'h0, 1'b0, o);
        rr_m = 1'b0;
    endtask

    task automatic test_random();
        obs_t o;
        bit pend [2] = '{0, 0};
        logic [68:0] att [2];
        bit w;
        int gd, rdl;
        logic [31:0] rd;
        bit er;
        for (int it = 0; it < 40; it++) begin
            for (int m = 0; m < 2; m++)
                if (!pend[m] && $urandom_range(0, 1) == 1) begin
                    pend[m] = 1'b1;
                    att[m] = {1'($urandom), 4'($urandom), $urandom, $urandom};
                    drive(1'(m), 1'b1, att[m]);
                end
            if (!pend[0] && !pend[1]) begin
                w = 1'($urandom);
                pend[w] = 1'b1;
                att[w] = {1'($urandom), 4'($urandom), $urandom, $urandom};
                drive(w, 1'b1, att[w]);
            end
            w = (pend[0] && pend[1]) ? rr_m : pend[1];
            gd = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
            rd = $urandom; er = 1'($urandom);
            serve(gd, rdl, rd, er, o);
            tests++;
            if ({o.req_seen, o.stable, o.req_dropped, o.spur} !== 4'b1110) begin
                fails++; $display("FAIL rnd_seq%0d: got %b exp 1110", it,
                    {o.req_seen, o.stable, o.req_dropped, o.spur});
            end
            tests++;
            if ({o.we, o.be, o.addr, o.wdata} !== att[w]) begin
                fails++; $display("FAIL rnd_attr%0d: got %h exp %h", it, {o.we, o.be, o.addr, o.wdata}, att[w]);
            end
            tests++;
            if ({o.g0, o.g1, o.rv0, o.rv1, o.e0, o.e1} !==
                {!w, w, !w, w, er && !w, er && w}) begin
                fails++; $display("FAIL rnd_hs%0d: got %b exp %b", it,
                    {o.g0, o.g1, o.rv0, o.rv1, o.e0, o.e1}, {!w, w, !w, w, er && !w, er && w});
            end
            tests++;
            if ({o.rd0, o.rd1} !== (w ? {IDLE_RD, rd} : {rd, IDLE_RD})) begin
                fails++; $display("FAIL rnd_rdata%0d: got %h %h exp owner m%0d=%h", it, o.rd0, o.rd1, w, rd);
            end
            pend[w] = 1'b0;
            rr_m = ~w;
        end
        i_m0_req = 0; i_m1_req = 0;
        @(posedge i_clk); @(negedge i_clk);
    endtask

    task automatic test_fixed_prio();
        int c0 = 0, c1 = 0, c1_early = 0, c0_early = 0;
        bit rvn = 0;
        fx_m0_req = 1; fx_m1_req = 1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge i_clk);
            fx_gnt_i = fx_req_o; fx_rvalid_i = rvn; #1;
            if (fx_m0_gnt) c0++;
            if (fx_m1_gnt) c1++;
            rvn = fx_gnt_i;
            if (cyc == 14) begin c0_early = c0; c1_early = c1; end
            if (cyc >= 15 && fx_m0_gnt) fx_m0_req = 0;
            if (fx_m1_gnt) fx_m1_req = 0;
        end
        fx_gnt_i = 0; fx_rvalid_i = 0; fx_m0_req = 0; fx_m1_req = 0;
        tests++;
        if (c1_early !== 0 || c0_early < 4) begin
            fails++; $display("FAIL fixed_starve: m0 gnts %0d (exp >=4) m1 gnts %0d (exp 0)", c0_early, c1_early);
        end
        tests++;
        if (c1 !== 1) begin
            fails++; $display("FAIL fixed_m1_after: m1 gnts got %0d exp 1", c1);
        end
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        bit early = 0;
        drive(0, 1, {1'b0, 4'hf, 32'h700, 32'h0});
        @(posedge i_clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge i_clk); #1;
            if (k < 8 && (o_m0_gnt | o_m0_rvalid | o_m0_err)) early = 1;
        end
        tests++;
        if ({early, o_m0_gnt, o_m0_rvalid, o_m0_err, o_m1_gnt, o_m1_rvalid, o_m0_rdata} !==
            {6'b011100, IDLE_RD}) begin
            fails++; $display("FAIL timeout_fire: got %b %h exp 011100 babecafe",
                {early, o_m0_gnt, o_m0_rvalid, o_m0_err, o_m1_gnt, o_m1_rvalid}, o_m0_rdata);
        end
        i_m0_req = 0;
        @(posedge i_clk); @(negedge i_clk);
        data_gnt_i = 1; data_rvalid_i = 1; #1;
        tests++;
        if ({data_req_o, o_m0_gnt, o_m0_rvalid} !== 3'b000) begin
            fails++; $display("FAIL timeout_after: got %b exp 000", {data_req_o, o_m0_gnt, o_m0_rvalid});
        end
        @(posedge i_clk); @(negedge i_clk); data_gnt_i = 0; data_rvalid_i = 0;
        rr_m = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_rr_order();
        test_single_load();
        test_store_err();
        test_reset_mid();
        test_random();
        test_fixed_prio();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
